// File: rtl/or_mask_unpacker.sv
// Sequential decoder that turns an OR-merged request mask into one source index per beat, lowest first.
// Optional zero-mask reporting beat is built when OR_UNPACK_ZERO_REPORT_EN is defined.
module or_mask_unpacker #(
  parameter int BitWidth   = 8,
  parameter int IndexWidth = $clog2(BitWidth)
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic [BitWidth-1:0]   In,
  input  logic                  InValid,
  output logic                  InReady,
  output logic [IndexWidth-1:0] Index,
  output logic                  Last,
  output logic                  Empty,
  output logic                  OutValid,
  input  logic                  OutReady
);

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  localparam logic [BitWidth-1:0] MaskOne = {{(BitWidth-1){1'b0}}, 1'b1};

  state_t              state;
  state_t              nextState;
  logic [BitWidth-1:0] mask;
  logic                accept;
  logic                fire;
  logic                lastBeat;

  function automatic logic [IndexWidth-1:0] lowestIdx(input logic [BitWidth-1:0] m);
    lowestIdx = '0;
    for (int i = BitWidth - 1; i >= 0; i--) begin
      if (m[i]) lowestIdx = IndexWidth'(i);
    end
  endfunction

  function automatic logic singleBit(input logic [BitWidth-1:0] m);
    singleBit = (m != '0) && ((m & (m - MaskOne)) == '0);
  endfunction

  function automatic logic [BitWidth-1:0] clearLowest(input logic [BitWidth-1:0] m);
    clearLowest = m & (m - MaskOne);
  endfunction

  assign accept = (state == IDLE) && InValid;
  assign fire   = (state == EMIT) && OutReady;

`ifdef OR_UNPACK_ZERO_REPORT_EN
  logic zeroPend;

  assign lastBeat = zeroPend || singleBit(mask);

  // zero-mask marker: set on accepting an all-zero word, cleared by its single beat
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      zeroPend <= 1'b0;
    end else if (accept) begin
      zeroPend <= (In == '0);
    end else if (fire && lastBeat) begin
      zeroPend <= 1'b0;
    end
  end
`else
  assign lastBeat = singleBit(mask);
`endif

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // mask accept / consume stage
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      mask <= '0;
    end else if (accept) begin
      mask <= In;
    end else if (fire) begin
      mask <= clearLowest(mask);
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
`ifdef OR_UNPACK_ZERO_REPORT_EN
        if (InValid) nextState = EMIT;
`else
        if (InValid && (In != '0)) nextState = EMIT;
`endif
      end
      EMIT: begin
        if (OutReady && lastBeat) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // outputs decode registers only; nothing here looks at InValid or OutReady
  always_comb begin
    InReady  = 1'b0;
    OutValid = 1'b0;
    Index    = '0;
    Last     = 1'b0;
    Empty    = 1'b0;
    case (state)
      IDLE: begin
        InReady = 1'b1;
      end
      EMIT: begin
        OutValid = 1'b1;
        Index    = lowestIdx(mask);
        Last     = lastBeat;
`ifdef OR_UNPACK_ZERO_REPORT_EN
        Empty    = zeroPend;
`endif
      end
      default: begin
        InReady = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_or_mask_unpacker.sv
// Scoreboard bench for or_mask_unpacker: directed scenarios followed by randomized masks and backpressure.
module tb_or_mask_unpacker;

  localparam int BW = 8;
  localparam int IW = 3;

  typedef struct {
    logic [IW-1:0] idx;
    logic          last;
    logic          empty;
  } beat_t;

  logic          Clk = 1'b0;
  logic          Reset_n = 1'b0;
  logic [BW-1:0] In = '0;
  logic          InValid = 1'b0;
  logic          InReady;
  logic [IW-1:0] Index;
  logic          Last;
  logic          Empty;
  logic          OutValid;
  logic          OutReady = 1'b0;

  int    tests = 0;
  int    fails = 0;
  bit    rndReady = 1'b0;
  beat_t expQ[$];

  or_mask_unpacker #(.BitWidth(BW)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .In(In), .InValid(InValid), .InReady(InReady),
    .Index(Index), .Last(Last), .Empty(Empty), .OutValid(OutValid), .OutReady(OutReady)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // reference: one beat per set bit, ascending; a zero mask yields a single empty beat only when reporting is built
  task automatic pushModel(input logic [BW-1:0] m);
    int rem;
    rem = $countones(m);
    if (m == '0) begin
`ifdef OR_UNPACK_ZERO_REPORT_EN
      expQ.push_back('{idx: '0, last: 1'b1, empty: 1'b1});
`endif
    end
    for (int i = 0; i < BW; i++) begin
      if (m[i]) begin
        rem--;
        expQ.push_back('{idx: IW'(i), last: (rem == 0), empty: 1'b0});
      end
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic sendMask(input logic [BW-1:0] m);
    int guard;
    guard = 0;
    while (!InReady && guard < 200) begin
      step();
      guard++;
    end
    if (!InReady) begin
      check("inReadyTimeout", 32'(InReady), 32'd1);
    end else begin
      In = m;
      InValid = 1'b1;
      pushModel(m);
      step();
      InValid = 1'b0;
      In = BW'($urandom);
    end
  endtask

  always @(posedge Clk) begin
    #1;
    if (rndReady) OutReady = (($urandom % 4) != 0);
  end

  // monitor: pops the scoreboard on every fired beat and checks stability across stalls
  bit            prevStall = 1'b0;
  logic [IW-1:0] prevIdx;
  logic          prevLast;
  logic          prevEmpty;
  always @(negedge Clk) begin
    if (!Reset_n) begin
      prevStall = 1'b0;
    end else begin
      if (prevStall) begin
        check("stallValid", 32'(OutValid), 32'd1);
        check("stallIndex", 32'(Index), 32'(prevIdx));
        check("stallLast", 32'(Last), 32'(prevLast));
        check("stallEmpty", 32'(Empty), 32'(prevEmpty));
      end
      if (!OutValid) check("idleIndexZero", 32'(Index), 32'd0);
      if (OutValid && OutReady) begin
        check("beatExpected", 32'(expQ.size() > 0), 32'd1);
        if (expQ.size() > 0) begin
          beat_t e;
          e = expQ.pop_front();
          check("beatIndex", 32'(Index), 32'(e.idx));
          check("beatLast", 32'(Last), 32'(e.last));
          check("beatEmpty", 32'(Empty), 32'(e.empty));
        end
      end
      prevStall = OutValid && !OutReady;
      prevIdx   = Index;
      prevLast  = Last;
      prevEmpty = Empty;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [BW-1:0] m;
    int guard;

    // reset state
    #12;
    check("rstInReady", 32'(InReady), 32'd1);
    check("rstOutValid", 32'(OutValid), 32'd0);
    check("rstIndex", 32'(Index), 32'd0);
    check("rstLast", 32'(Last), 32'd0);
    check("rstEmpty", 32'(Empty), 32'd0);
    step();
    Reset_n = 1'b1;
    step();

    // reset mid-EMIT abandons the remaining bit 5
    OutReady = 1'b1;
    sendMask(8'b0010_1001);
    check("rmidIdx0", 32'(Index), 32'd0);
    step();
    check("rmidIdx3", 32'(Index), 32'd3);
    step();
    Reset_n = 1'b0;
    expQ.delete();
    #1;
    check("rmidOutValid", 32'(OutValid), 32'd0);
    check("rmidInReady", 32'(InReady), 32'd1);
    check("rmidIndex", 32'(Index), 32'd0);
    check("rmidLast", 32'(Last), 32'd0);
    step();
    step();
    Reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("rmidNoBeat", 32'(OutValid), 32'd0);
    end

    // full mask: eight consecutive beats, then ready again
    sendMask(8'hFF);
    for (int k = 0; k < 8; k++) begin
      check("fullValid", 32'(OutValid), 32'd1);
      check("fullIndex", 32'(Index), 32'(k));
      check("fullLast", 32'(Last), 32'(k == 7));
      step();
    end
    check("fullInReady", 32'(InReady), 32'd1);
    check("fullOutValid", 32'(OutValid), 32'd0);

    // backpressure on the first beat
    OutReady = 1'b0;
    sendMask(8'b1000_0100);
    for (int i = 0; i < 3; i++) begin
      check("bpValid", 32'(OutValid), 32'd1);
      check("bpIndex", 32'(Index), 32'd2);
      check("bpLast", 32'(Last), 32'd0);
      step();
    end
    check("bpIndexHeld", 32'(Index), 32'd2);
    OutReady = 1'b1;
    step();
    check("bpIndex7", 32'(Index), 32'd7);
    check("bpLast7", 32'(Last), 32'd1);
    step();
    check("bpDone", 32'(OutValid), 32'd0);

    // zero mask
    sendMask(8'h00);
`ifdef OR_UNPACK_ZERO_REPORT_EN
    check("zeroValid", 32'(OutValid), 32'd1);
    check("zeroEmpty", 32'(Empty), 32'd1);
    check("zeroIndex", 32'(Index), 32'd0);
    check("zeroLast", 32'(Last), 32'd1);
    step();
    check("zeroDone", 32'(OutValid), 32'd0);
`else
    for (int i = 0; i < 4; i++) begin
      check("zeroNoValid", 32'(OutValid), 32'd0);
      check("zeroInReady", 32'(InReady), 32'd1);
      step();
    end
`endif

    // back-to-back masks with InValid held high
    In = 8'h10;
    InValid = 1'b1;
    pushModel(8'h10);
    pushModel(8'h01);
    step();
    In = 8'h01;
    check("b2bValid1", 32'(OutValid), 32'd1);
    check("b2bIndex4", 32'(Index), 32'd4);
    check("b2bLast1", 32'(Last), 32'd1);
    check("b2bBusy", 32'(InReady), 32'd0);
    step();
    check("b2bGapValid", 32'(OutValid), 32'd0);
    check("b2bGapReady", 32'(InReady), 32'd1);
    step();
    InValid = 1'b0;
    check("b2bValid2", 32'(OutValid), 32'd1);
    check("b2bIndex0", 32'(Index), 32'd0);
    check("b2bLast2", 32'(Last), 32'd1);
    step();
    check("b2bDone", 32'(OutValid), 32'd0);

    // randomized masks under random backpressure
    rndReady = 1'b1;
    for (int n = 0; n < 150; n++) begin
      case ($urandom % 4)
        0: m = BW'($urandom);
        1: m = BW'(1) << ($urandom % BW);
        2: m = (($urandom % 3) == 0) ? '0 : BW'($urandom | $urandom);
        default: m = BW'($urandom & $urandom);
      endcase
      sendMask(m);
      repeat ($urandom % 3) step();
    end
    rndReady = 1'b0;
    step();
    OutReady = 1'b1;
    guard = 0;
    while ((expQ.size() != 0 || OutValid) && guard < 100) begin
      step();
      guard++;
    end
    check("drainQueue", 32'(expQ.size()), 32'd0);
    check("drainIdle", 32'(OutValid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
